weight_read_ctrl: RTL
=====================

Name: weight_read_ctrl

Overview:
- Sequences reads from the dual-port weight memory bank: two pixel addresses per cycle (lane 0 even, lane 1 odd) across all class columns in parallel.
- Owns the memory load window after reset, the start/busy/done handshake with the top-level FSM, and stall handling.
- Produces MAC-enable strobes aligned to memory read latency.
- Sits between the inference FSM and the weight memory plus the per-class MAC array.

Parameters:
- NPIX, 784, number of input pixels / weight rows per class column (>=1; odd allowed)
- ADDR_W, 10, address width to the weight memory
- RD_LAT, 1, weight memory read latency in cycles (1..4)
- LOAD_CYCLES, 9, cycles the load output is held after reset (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one pass over NPIX rows; sampled only in IDLE
- stall  in  1  pixel source not ready; freezes address advance
- load  out  1  memory load window, high during LOAD state
- addr1  out  ADDR_W  lane-0 address (even rows)
- addr2  out  ADDR_W  lane-1 address (odd rows)
- valid_weight2  out  1  lane-1 address is a real row (drives validWeight2)
- busy  out  1  high in RUN and DRAIN
- mac_en  out  1  lane-0 weight data valid at memory output this cycle
- mac_en2  out  1  lane-1 weight data valid at memory output this cycle
- last  out  1  coincides with mac_en of the final pair
- done  out  1  one-cycle pulse after the final pair has been presented

Behaviour:
- Clock and reset: one clock, clk; reset is rst, synchronous and active-high.
- Reset values: state=LOAD, load=1, addr1=0, addr2=1 (0 if NPIX==1), valid_weight2=0, busy=0, mac_en=0, mac_en2=0, last=0, done=0; load countdown=LOAD_CYCLES-1; delay pipeline cleared.
- Reset mid-operation aborts RUN/DRAIN immediately. No done is issued, and the controller re-enters LOAD.
- LOAD:
  - load=1 for exactly LOAD_CYCLES cycles after rst deasserts, then go to IDLE.
  - start is ignored while in LOAD.
- IDLE:
  - load=0, addresses held at 0/1.
  - start=1 -> RUN next cycle; pair index k=0.
- RUN:
  - Issue pair k each cycle stall=0: addr1=2k, addr2=2k+1, issue strobe=1.
  - valid_weight2=1 iff 2k+1 < NPIX. When it is 0, addr2 is driven 0.
  - stall=1: addresses hold, issue strobe=0, k holds.
  - After issuing the final pair (k = ceil(NPIX/2)-1) with stall=0 -> DRAIN.
  - start is ignored in RUN.
- Delay pipeline:
  - RD_LAT-stage shift of {issue, valid_weight2&issue, final}.
  - Outputs mac_en, mac_en2 and last are registered from it, so mac_en is high exactly RD_LAT cycles after an unstalled issue.
  - The pipeline always shifts; stall does not freeze in-flight data.
- DRAIN:
  - No new issues; wait until the last flag exits the pipeline (the cycle last=1).
  - done=1 on the following cycle, then go to IDLE.
  - busy drops in the same cycle done=1.
- Counts:
  - Total mac_en pulses per pass = ceil(NPIX/2).
  - Total mac_en2 pulses = floor(NPIX/2).
- start arriving in the same cycle as done (state still DRAIN->IDLE) is ignored; the FSM must reassert it in IDLE.
- Address arithmetic is unsigned ADDR_W bits; NPIX <= 2^ADDR_W is required (elaboration error otherwise).

Optional Feature:
- Macro: WEIGHT_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles in RUN with stall=1.
  - stall_cnt clears on entry to RUN and holds its value after done; it saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, no start, NPIX=784, LOAD_CYCLES=9 -> load high exactly 9 cycles after rst falls; all other outputs at reset values; busy=0.
- start in IDLE, no stall, RD_LAT=1 -> addr pairs (0,1),(2,3)..(782,783) on 392 consecutive cycles; mac_en/mac_en2 high 392 cycles each, lagging by 1; last on the final one; done one cycle later.
- NPIX=5, RD_LAT=2 -> pairs (0,1),(2,3),(4,0); valid_weight2 = 1,1,0; mac_en=3 pulses, mac_en2=2; last with the 3rd mac_en.
- stall high for 4 cycles at k=10 -> addr1 held at 20 for 4 extra cycles; mac_en gap of 4; pulse totals unchanged (392/392); with WEIGHT_CTRL_PERF_EN, stall_cnt=4 after done.
- rst asserted during RUN at k=100 -> next cycle load=1, busy=0, mac_en=0, addr1=0; no done; after 9 load cycles, a new start produces a full clean pass.
- start pulsed during RUN and in the done cycle -> ignored; exactly one pass and one done.

Source files
------------

// File: rtl/weight_read_ctrl.sv
// Weight-memory read sequencer: load window after reset, then two-lane (even/odd row) address passes with MAC strobes.
// Optional build macro WEIGHT_CTRL_PERF_EN adds the stall_cnt output.
module weight_read_ctrl #(
  parameter int NPIX        = 784,
  parameter int ADDR_W      = 10,
  parameter int RD_LAT      = 1,
  parameter int LOAD_CYCLES = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              load,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              valid_weight2,
  output logic              busy,
  output logic              mac_en,
  output logic              mac_en2,
  output logic              last,
  output logic              done
`ifdef WEIGHT_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int                NPAIRS  = (NPIX + 1) / 2;
  localparam int                LC_W    = $clog2(LOAD_CYCLES + 1);
  localparam logic [31:0]       NPIX_U  = NPIX;
  localparam logic [ADDR_W-1:0] LAST_A1 = ADDR_W'(2 * (NPAIRS - 1));
  localparam logic [ADDR_W-1:0] A2_INIT = (NPIX > 1) ? ADDR_W'(1) : '0;
  localparam logic              VW2_INIT = (NPIX > 1);

  if (NPIX < 1 || 64'(NPIX) > (64'd1 << ADDR_W) || RD_LAT < 1 || RD_LAT > 4 ||
      LOAD_CYCLES < 1) begin : g_param_err
    $error("weight_read_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state;

  logic [LC_W-1:0]   load_cnt;
  logic [RD_LAT-1:0] pe, pe2, pl;
  logic              issue, final_pair, vw2_next;
  logic [31:0]       a2_next_w;

  // Handshake: start is honoured only in IDLE; busy is high from the first RUN
  // cycle until the done cycle, and done is a single-cycle pulse in which busy is 0.
  assign issue      = (state == S_RUN) && !stall;
  assign final_pair = (addr1 == LAST_A1);
  assign a2_next_w  = 32'(addr1) + 32'd3;
  assign vw2_next   = (a2_next_w < NPIX_U);

  assign mac_en  = pe[RD_LAT-1];
  assign mac_en2 = pe2[RD_LAT-1];
  assign last    = pl[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      load          <= 1'b1;
      load_cnt      <= LC_W'(LOAD_CYCLES - 1);
      addr1         <= '0;
      addr2         <= A2_INIT;
      valid_weight2 <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pe            <= '0;
      pe2           <= '0;
      pl            <= '0;
`ifdef WEIGHT_CTRL_PERF_EN
      stall_cnt     <= '0;
`endif
    end else begin
      // The latency pipe keeps shifting during stalls so in-flight reads still land.
      pe[0]  <= issue;
      pe2[0] <= issue && valid_weight2;
      pl[0]  <= issue && final_pair;
      for (int i = 1; i < RD_LAT; i++) begin
        pe[i]  <= pe[i-1];
        pe2[i] <= pe2[i-1];
        pl[i]  <= pl[i-1];
      end

      case (state)
        S_LOAD: begin
          if (load_cnt == '0) begin
            state <= S_IDLE;
            load  <= 1'b0;
          end else begin
            load_cnt <= load_cnt - LC_W'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            state         <= S_RUN;
            busy          <= 1'b1;
            addr1         <= '0;
            addr2         <= A2_INIT;
            valid_weight2 <= VW2_INIT;
`ifdef WEIGHT_CTRL_PERF_EN
            stall_cnt     <= '0;
`endif
          end
        end
        S_RUN: begin
          if (stall) begin
`ifdef WEIGHT_CTRL_PERF_EN
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
          end else if (final_pair) begin
            state         <= S_DRAIN;
            addr1         <= '0;
            addr2         <= A2_INIT;
            valid_weight2 <= 1'b0;
          end else begin
            addr1         <= addr1 + ADDR_W'(2);
            addr2         <= vw2_next ? addr1 + ADDR_W'(3) : '0;
            valid_weight2 <= vw2_next;
          end
        end
        S_DRAIN: begin
          // Stay in DRAIN through the done cycle so a start there is not taken.
          if (done) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (last) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
